// File: rtl/clk_burst_pkg.sv
// ============================================================================
// clk_burst_pkg : shared state encoding and default constants for clk_burst_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_burst_pkg;

  localparam int c_CNT_W      = 16;
  localparam int c_BURST_W    = 8;
  localparam int c_DEF_PERIOD = 10;
  localparam int c_DEF_HIGH   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/phase_counter.sv
// ============================================================================
// phase_counter : loadable down-counter with zero flag, saturating at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/clk_burst_ctrl.sv
// ============================================================================
// clk_burst_ctrl : programmable-duty clock generator running counted or free bursts
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_burst_ctrl
  import clk_burst_pkg::*;
#(
  parameter int CNT_W      = c_CNT_W,
  parameter int BURST_W    = c_BURST_W,
  parameter int DEF_PERIOD = c_DEF_PERIOD,
  parameter int DEF_HIGH   = c_DEF_HIGH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               gclk,
  output logic               gen_enable,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_high;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_periods;
  logic               r_cfg_err;
  logic               r_stop_pend;
  logic               r_gclk;
  logic               r_done;

  logic               w_cfg_ok;
  logic               w_cfg_acc;
  logic [CNT_W-1:0]   w_high_eff;
  logic [BURST_W-1:0] w_periods_inc;
  logic               w_last;
  logic               w_ld;
  logic [CNT_W-1:0]   w_ld_val;
  logic               w_dec;
  logic               w_zero;

  assign w_cfg_ok      = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
  assign w_cfg_acc     = cfg_valid && (r_state == ST_IDLE);
  // A start coinciding with an accepted config must time its first HIGH from the new value
  assign w_high_eff    = (w_cfg_acc && w_cfg_ok) ? cfg_high : r_high;
  assign w_periods_inc = r_periods + BURST_W'(1);
  assign w_last        = r_stop_pend || stop || ((r_burst != '0) && (w_periods_inc == r_burst));

  phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ld         = 1'b0;
    w_ld_val     = '0;
    w_dec        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_HIGH;
          w_ld         = 1'b1;
          w_ld_val     = w_high_eff - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (w_zero) begin
          w_state_next = ST_LOW;
          w_ld         = 1'b1;
          w_ld_val     = r_period - r_high - CNT_W'(1);
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_zero) begin
          if (w_last) begin
            w_state_next = ST_FINISH;
          end else begin
            w_state_next = ST_HIGH;
            w_ld         = 1'b1;
            w_ld_val     = r_high - CNT_W'(1);
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period    <= CNT_W'(DEF_PERIOD);
      r_high      <= CNT_W'(DEF_HIGH);
      r_burst     <= '0;
      r_periods   <= '0;
      r_cfg_err   <= 1'b0;
      r_stop_pend <= 1'b0;
      r_gclk      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_gclk <= (w_state_next == ST_HIGH);
      r_done <= (w_state_next == ST_FINISH);
      if (w_cfg_acc) begin
        if (w_cfg_ok) begin
          r_period  <= cfg_period;
          r_high    <= cfg_high;
          r_burst   <= cfg_burst;
          r_cfg_err <= 1'b0;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
      if (r_state == ST_IDLE) begin
        r_stop_pend <= 1'b0;
        r_periods   <= '0;
      end else begin
        if (stop && ((r_state == ST_HIGH) || (r_state == ST_LOW))) begin
          r_stop_pend <= 1'b1;
        end
        if ((r_state == ST_LOW) && w_zero) begin
          r_periods <= w_periods_inc;
        end
      end
    end
  end

  assign gclk       = r_gclk;
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;
  assign cfg_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign gen_enable = (r_state == ST_HIGH) || (r_state == ST_LOW);

endmodule

`default_nettype wire

// File: doc/clk_burst_ctrl.md
CLK_BURST_CTRL -- requirements
Module: clk_burst_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of period/high-time counters.
REQ-002 SHALL have parameter BURST_W, default 8: width of burst-count field.
REQ-003 SHALL have parameter DEF_PERIOD, default 10: period in clk cycles after reset.
REQ-004 SHALL have parameter DEF_HIGH, default 5: high time in clk cycles after reset.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_valid  input  1  configuration offered.
REQ-008 SHALL have port cfg_ready  output  1  configuration can be accepted.
REQ-009 SHALL have port cfg_period  input  CNT_W  clock period in clk cycles.
REQ-010 SHALL have port cfg_high  input  CNT_W  high phase in clk cycles (duty).
REQ-011 SHALL have port cfg_burst  input  BURST_W  periods per burst; 0 = free-running.
REQ-012 SHALL have port start  input  1  single-cycle pulse to begin a burst.
REQ-013 SHALL have port stop  input  1  single-cycle pulse to end a burst.
REQ-014 SHALL have port gclk  output  1  generated clock, registered.
REQ-015 SHALL have port gen_enable  output  1  high while a burst is running.
REQ-016 SHALL have port busy  output  1  state is not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-018 SHALL have port cfg_err  output  1  sticky flag: last offered config rejected.

Function
REQ-019 SHALL implement states IDLE, HIGH, LOW, FINISH.
REQ-020 SHALL assert cfg_ready only in IDLE; config captured on edge where cfg_valid and cfg_ready are both high.
REQ-021 SHALL reject config with cfg_period < 2, cfg_high = 0, or cfg_high >= cfg_period: registers unchanged, cfg_err set; a valid accepted config clears cfg_err.
REQ-022 SHALL accept start only in IDLE; start at edge t -> HIGH with gclk = 1 from edge t+1.
REQ-023 SHALL hold gclk = 1 for exactly high cycles (HIGH), then gclk = 0 for exactly period-high cycles (LOW); counters CNT_W bits, count down, no wrap.
REQ-024 SHALL count completed periods at end of each LOW; when count equals nonzero burst, go to FINISH instead of HIGH.
REQ-025 SHALL, for burst = 0, repeat HIGH/LOW until stop.
REQ-026 SHALL on stop in HIGH or LOW complete the current period (no truncated high pulse), then go to FINISH.
REQ-027 SHALL pulse done for one cycle in FINISH, then return to IDLE next edge; gclk = 0 in FINISH.
REQ-028 SHALL assert gen_enable in HIGH and LOW only; busy in HIGH, LOW, FINISH.
REQ-029 SHALL ignore start when not IDLE; ignore stop in IDLE and FINISH.
REQ-030 SHALL, on start and stop in same IDLE cycle, start the burst and ignore stop.
REQ-031 SHALL, on cfg handshake and start in same IDLE cycle, run the burst with the newly accepted config.

Reset
REQ-032 SHALL on rst: state IDLE, period = DEF_PERIOD, high = DEF_HIGH, burst = 0, gclk = 0, gen_enable = 0, busy = 0, done = 0, cfg_err = 0, cfg_ready = 1 on next cycle.
REQ-033 SHALL let rst mid-burst override all inputs and force gclk low on the same edge, with no done pulse.

Structure
REQ-034 SHALL place state enum, CNT_W/BURST_W defaults and DEF_PERIOD/DEF_HIGH constants in shared package clk_burst_pkg.
REQ-035 SHALL use one sub-module, phase_counter (loadable down-counter with zero flag), for the HIGH/LOW phase timing.

Verification
REQ-036 SHALL cover reset defaults: rst, start -> gclk 5 high / 5 low repeating, gen_enable = 1, done never.
REQ-037 SHALL cover burst: cfg period 4, high 1, burst 3, start -> exactly 3 one-cycle high pulses 4 cycles apart, done one cycle after 3rd LOW ends.
REQ-038 SHALL cover rejection: cfg period 4, high 4 -> cfg_err = 1, next burst uses prior config; cfg 6/3 -> cfg_err = 0.
REQ-039 SHALL cover stop mid-HIGH: period 8, high 4, burst 0, stop at 2nd HIGH cycle -> full 4-high/4-low, then FINISH, done, IDLE.
REQ-040 SHALL cover reset mid-LOW and start while busy: rst -> gclk 0, busy 0 next edge, no done; start during HIGH -> no period restart.
